// File: rtl/uart_rx_router.sv
// Receive-side router: buffers UART bytes in a FIFO, parses {len,dest} framed packets
// and hands each payload to one of NUM_DEST consumers over valid/ready.
module uart_rx_router #(
    parameter int NUM_DEST       = 4,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          out_data,
    output logic [NUM_DEST-1:0] out_valid,
    input  logic [NUM_DEST-1:0] out_ready,
    output logic                out_last,
    output logic                frame_done,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err,
    output logic [7:0]          drop_count,
    input  logic                clear_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // state   | meaning
    // IDLE    | waiting for a header byte in the FIFO
    // PAYLOAD | presenting payload bytes to channel dest
    // DISCARD | silently popping payload of a frame with no such destination
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      remaining;
    logic [3:0]      dest;
    logic [TW-1:0]   tmo_cnt;

    logic            empty;
    logic            full;
    logic            wr_en;
    logic            pop;
    logic            sel_ready;
    logic [7:0]      head;
    logic            tmo_hit;
    logic            drop_inc;

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign wr_en = rx_valid && !full;
    assign head  = mem[rd_ptr];

    always_comb begin
        out_valid = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_DEST; i++) begin
            if (dest == 4'(i)) begin
                out_valid[i] = (state == PAYLOAD) && !empty;
                sel_ready    = out_ready[i];
            end
        end
    end

    assign out_data = (state == PAYLOAD && !empty) ? head : 8'h00;
    assign out_last = (state == PAYLOAD) && (remaining == 4'd1);
    assign busy     = (state != IDLE);

    assign pop = !empty && ((state == IDLE) ||
                            (state == DISCARD) ||
                            (state == PAYLOAD && sel_ready));

    // Abort on the TIMEOUT_CYCLES-th consecutive empty, write-free cycle mid-frame.
    assign tmo_hit  = (state != IDLE) && empty && !rx_valid && (tmo_cnt == TW'(1));
    assign drop_inc = tmo_hit || (state == DISCARD && pop && remaining == 4'd1);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            dest        <= '0;
            tmo_cnt     <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            drop_count  <= '0;
        end else begin
            frame_done <= 1'b0;

            // Clear first so a same-cycle set overrides it.
            if (clear_err) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
                drop_count  <= '0;
            end
            if (rx_valid && full) overrun <= 1'b1;
            if (tmo_hit) timeout_err <= 1'b1;
            if (drop_inc) drop_count <= (drop_count == 8'hFF) ? 8'hFF : drop_count + 8'd1;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        remaining <= head[7:4];
                        dest      <= head[3:0];
                        tmo_cnt   <= TW'(TIMEOUT_CYCLES);
                        if (head[7:4] == 4'd0)
                            frame_done <= 1'b1;
                        else if (int'(head[3:0]) >= NUM_DEST)
                            state <= DISCARD;
                        else
                            state <= PAYLOAD;
                    end
                end
                PAYLOAD, DISCARD: begin
                    if (pop) begin
                        remaining <= remaining - 4'd1;
                        if (remaining == 4'd1) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end
                    end
                    if (rx_valid) begin
                        tmo_cnt <= TW'(TIMEOUT_CYCLES);
                    end else if (empty) begin
                        if (tmo_hit) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_router.sv
// Self-checking bench for uart_rx_router: table-driven frames, directed corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_rx_router;

    localparam int ND = 4;
    localparam int FD = 16;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    out_data;
    logic [ND-1:0] out_valid;
    logic [ND-1:0] out_ready;
    logic [ND-1:0] fix_ready = '0;
    logic [ND-1:0] rnd_ready = '0;
    logic          rand_mode = 1'b0;
    logic          out_last;
    logic          frame_done;
    logic          busy;
    logic          overrun;
    logic          timeout_err;
    logic [7:0]    drop_count;
    logic          clear_err = 1'b0;

    assign out_ready = rand_mode ? rnd_ready : fix_ready;

    uart_rx_router #(.NUM_DEST(ND), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err), .drop_count(drop_count),
        .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_drop = 0;

    logic [12:0] obs_q[$];
    logic [12:0] exp_q[$];
    int          fd_cnt = 0;
    logic [ND-1:0] vld_or = '0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Transfers are recorded as {channel, last, data}.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) fd_cnt++;
            vld_or = vld_or | out_valid;
            if (out_valid != '0) check("valid_onehot", $countones(out_valid), 1);
            for (int i = 0; i < ND; i++)
                if (out_valid[i] && out_ready[i])
                    obs_q.push_back({4'(i), out_last, out_data});
        end
    end

    always begin
        @(posedge clk);
        #1;
        rnd_ready = ND'($urandom | $urandom);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic clr_mon();
        obs_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        vld_or = '0;
    endtask

    task automatic wait_frames(input int n, input int limit);
        int c;
        c = 0;
        while (fd_cnt < n && c < limit) begin
            tick();
            c++;
        end
        check("frames_done", fd_cnt, n);
    endtask

    task automatic check_obs(input string name);
        check({name, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(name, int'(obs_q[i]), int'(exp_q[i]));
    endtask

    typedef struct {
        logic [7:0]    hdr;
        logic [23:0]   pl;       // first payload byte in [7:0]
        logic [ND-1:0] exp_vld;
        int            exp_ch;
        int            exp_ndel;
        int            exp_drop;
    } vec_t;

    localparam int NT = 9;
    vec_t tbl [NT];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first_fd;
        int pulses;
        logic busy_pre;
        logic busy_at;
        logic [7:0] b;
        logic [3:0] len;
        logic [3:0] dst;

        tbl[0] = '{8'h21, 24'h00BBAA, 4'b0010, 1, 2, 0};
        tbl[1] = '{8'h37, 24'h332211, 4'b0000, 0, 0, 1};
        tbl[2] = '{8'h10, 24'h000099, 4'b0001, 0, 1, 0};
        tbl[3] = '{8'h00, 24'h000000, 4'b0000, 0, 0, 0};
        tbl[4] = '{8'h23, 24'h003CC3, 4'b1000, 3, 2, 0};
        tbl[5] = '{8'h1F, 24'h00005A, 4'b0000, 0, 0, 1};
        tbl[6] = '{8'h12, 24'h000066, 4'b0100, 2, 1, 0};
        tbl[7] = '{8'h3C, 24'h030201, 4'b0000, 0, 0, 1};
        tbl[8] = '{8'h04, 24'h000000, 4'b0000, 0, 0, 0};

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_out_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven single frames, all consumers ready
        for (int t = 0; t < NT; t++) begin
            clr_mon();
            fix_ready = '1;
            send(tbl[t].hdr);
            n = int'(tbl[t].hdr[7:4]);
            for (int k = 0; k < n; k++) send(tbl[t].pl[8*k +: 8]);
            for (int k = 0; k < tbl[t].exp_ndel; k++)
                exp_q.push_back({4'(tbl[t].exp_ch), k == tbl[t].exp_ndel - 1, tbl[t].pl[8*k +: 8]});
            exp_drop += tbl[t].exp_drop;
            wait_frames(1, 100);
            repeat (2) tick();
            check("tbl_valid_seen", vld_or, tbl[t].exp_vld);
            check_obs("tbl_xfer");
            check("tbl_frame_pulses", fd_cnt, 1);
            check("tbl_drop_count", drop_count, exp_drop);
            check("tbl_busy", busy, 0);
        end

        // Consumer stall: data and valid hold, other channels' ready ignored
        clr_mon();
        fix_ready = 4'b1011;
        send(8'h12);
        send(8'h55);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 4'b0100);
            check("stall_data", out_data, 8'h55);
            check("stall_last", out_last, 1);
            tick();
        end
        check("stall_no_xfer", obs_q.size(), 0);
        fix_ready = 4'b1111;
        @(negedge clk);
        check("stall_valid_first_ready", out_valid, 4'b0100);
        tick();
        @(negedge clk);
        exp_q.push_back({4'd2, 1'b1, 8'h55});
        check_obs("stall_xfer");
        check("stall_frame_done", frame_done, 1);
        check("stall_valid_after", out_valid, 0);
        tick();

        // Overrun under stall; set wins over a simultaneous clear
        clr_mon();
        fix_ready = '0;
        send(8'hF0);
        for (int k = 1; k <= 15; k++) send(8'(k));
        send(8'h00);
        @(negedge clk);
        check("ovr_not_yet", overrun, 0);
        tick();
        rx_data = 8'hEE;
        rx_valid = 1'b1;
        clear_err = 1'b1;
        tick();
        rx_valid = 1'b0;
        clear_err = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        check("ovr_set_wins", overrun, 1);
        check("ovr_drop_cleared", drop_count, 0);
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        @(negedge clk);
        check("ovr_cleared", overrun, 0);
        tick();
        fix_ready = '1;
        for (int k = 1; k <= 15; k++) exp_q.push_back({4'd0, k == 15, 8'(k)});
        wait_frames(2, 200);
        repeat (2) tick();
        check_obs("ovr_xfer");
        check("ovr_busy", busy, 0);

        // Inter-byte timeout: 1 of 3 payload bytes, then silence
        clr_mon();
        fix_ready = '1;
        send(8'h30);
        send(8'h77);
        first_fd = -1;
        pulses = 0;
        busy_pre = 1'b0;
        busy_at = 1'b1;
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            if (frame_done) begin
                pulses++;
                if (first_fd < 0) first_fd = k;
            end
            if (k == 100) busy_pre = busy;
            if (k == 101) busy_at = busy;
            tick();
        end
        exp_drop = 1;
        exp_q.push_back({4'd0, 1'b0, 8'h77});
        check("tmo_cycle", first_fd, 101);
        check("tmo_pulses", pulses, 1);
        check("tmo_busy_before", busy_pre, 1);
        check("tmo_busy_after", busy_at, 0);
        check("tmo_err", timeout_err, 1);
        check("tmo_drop_count", drop_count, exp_drop);
        check_obs("tmo_xfer");
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        check("tmo_err_cleared", timeout_err, 0);
        tick();

        // Reset mid-PAYLOAD
        clr_mon();
        fix_ready = '0;
        send(8'h21);
        send(8'hAA);
        send(8'hBB);
        @(negedge clk);
        check("rstmid_valid_before", out_valid, 4'b0010);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        fix_ready = '1;
        clr_mon();
        repeat (10) tick();
        check("rstmid_flushed_valid", vld_or, 0);
        check("rstmid_flushed_frames", fd_cnt, 0);
        check("rstmid_flushed_busy", busy, 0);

        // Randomized frames against the frame-level model
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            clr_mon();
            len = 4'($urandom_range(0, 15));
            dst = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, ND - 1));
            send({len, dst});
            for (int k = 0; k < int'(len); k++) begin
                repeat ($urandom_range(0, 3)) tick();
                b = 8'($urandom);
                if (int'(dst) < ND) exp_q.push_back({dst, k == int'(len) - 1, b});
                send(b);
            end
            if (len != 0 && int'(dst) >= ND) exp_drop++;
            wait_frames(1, 600);
            repeat (2) tick();
            check_obs("rnd_xfer");
            check("rnd_drop_count", drop_count, exp_drop);
        end
        rand_mode = 1'b0;
        check("rnd_overrun", overrun, 0);
        check("rnd_timeout_err", timeout_err, 0);

        // drop_count saturation
        clr_mon();
        for (int f = 0; f < 256; f++) begin
            send(8'h15);
            send(8'h00);
        end
        exp_drop = (exp_drop + 256 > 255) ? 255 : exp_drop + 256;
        repeat (6) tick();
        check("sat_drop_count", drop_count, exp_drop);
        check("sat_frames", fd_cnt, 256);
        check("sat_valid_seen", vld_or, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
